// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-search sequencer.
//   rc4_state_e : phase controller state encoding
//   KEY_BITS    : default candidate key width (3 bytes of 8 bits)
package rc4_pkg;

  localparam int KEY_BITS = 24;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_RUN,
    ST_SHUF_GO,
    ST_SHUF_RUN,
    ST_DEC_GO,
    ST_DEC_RUN,
    ST_NEXT_KEY,
    ST_DONE
  } rc4_state_e;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector.
//   clk : clock
//   in  : level input
//   out : high in the cycle where in is high and was low on the previous edge
// The output is combinational so the edge is acted on at the first edge
// that samples the input high.
module edge_detector (
  input  logic clk,
  input  logic in,
  output logic out
);

  logic in_q;

  always_ff @(posedge clk) in_q <= in;

  assign out = in & ~in_q;

endmodule

// File: rtl/rc4_phase_controller.sv
// RC4 key-search phase controller: runs init -> shuffle -> decrypt for each
// candidate key, owns the single-port S-RAM bus, and steps the key until
// decrypt reports a valid plaintext or the key range is exhausted.
//   clk, reset              : clock, synchronous active-high reset
//   start                   : run request (rising edge)
//   busy, done, found, key  : status and current/final candidate key
//   *_start / *_finished    : engine handshake (start level, done pulse)
//   decrypt_valid           : plaintext check result, with decrypt_finished
//   *_address/_ram_in/_write_enable : engine S-RAM requests
//   s_address/s_ram_in/s_write_enable : granted request to the S-RAM
module rc4_phase_controller
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_LENGTH = 8,
  parameter int KEY_LENGTH = 3,
  parameter int KEY_START  = 0,
  parameter int KEY_END    = 24'h3FFFFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   found,
  output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0]   key,
  output logic                                   init_start,
  output logic                                   shuffle_start,
  output logic                                   decrypt_start,
  input  logic                                   init_finished,
  input  logic                                   shuffle_finished,
  input  logic                                   decrypt_finished,
  input  logic                                   decrypt_valid,
  input  logic [RAM_LENGTH-1:0]                  init_address,
  input  logic [RAM_LENGTH-1:0]                  shuffle_address,
  input  logic [RAM_LENGTH-1:0]                  decrypt_address,
  input  logic [RAM_WIDTH-1:0]                   init_ram_in,
  input  logic [RAM_WIDTH-1:0]                   shuffle_ram_in,
  input  logic [RAM_WIDTH-1:0]                   decrypt_ram_in,
  input  logic                                   init_write_enable,
  input  logic                                   shuffle_write_enable,
  input  logic                                   decrypt_write_enable,
  output logic [RAM_LENGTH-1:0]                  s_address,
  output logic [RAM_WIDTH-1:0]                   s_ram_in,
  output logic                                   s_write_enable
);

  localparam int              KB        = KEY_LENGTH * RAM_WIDTH;
  localparam logic [KB-1:0]   KEY_FIRST = KB'(KEY_START);
  localparam logic [KB-1:0]   KEY_LAST  = KB'(KEY_END);

  rc4_state_e    state_q, state_d;
  logic [KB-1:0] key_q, key_d;
  logic          found_q, found_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          init_start_q, init_start_d;
  logic          shuffle_start_q, shuffle_start_d;
  logic          decrypt_start_q, decrypt_start_d;
  logic          start_rise;

  edge_detector u_start_edge (
    .clk (clk),
    .in  (start),
    .out (start_rise)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    found_d = found_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_rise) begin
        state_d = ST_INIT_GO;
        key_d   = KEY_FIRST;
        found_d = 1'b0;
      end
      // GO states hold the engine start low for one cycle so every engine
      // sees a clean rising edge, even on back-to-back attempts.
      ST_INIT_GO:  state_d = ST_INIT_RUN;
      ST_INIT_RUN: if (init_finished) state_d = ST_SHUF_GO;
      ST_SHUF_GO:  state_d = ST_SHUF_RUN;
      ST_SHUF_RUN: if (shuffle_finished) state_d = ST_DEC_GO;
      ST_DEC_GO:   state_d = ST_DEC_RUN;
      ST_DEC_RUN: if (decrypt_finished) begin
        if (decrypt_valid) begin
          state_d = ST_DONE;
          found_d = 1'b1;
        end else if (key_q == KEY_LAST) begin
          state_d = ST_DONE;
          found_d = 1'b0;
        end else begin
          state_d = ST_NEXT_KEY;
        end
      end
      ST_NEXT_KEY: begin
        key_d   = key_q + 1'b1;
        state_d = ST_INIT_GO;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    init_start_d    = (state_d == ST_INIT_RUN);
    shuffle_start_d = (state_d == ST_SHUF_RUN);
    decrypt_start_d = (state_d == ST_DEC_RUN);
    busy_d          = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d          = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      key_q           <= KEY_FIRST;
      found_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      init_start_q    <= 1'b0;
      shuffle_start_q <= 1'b0;
      decrypt_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      key_q           <= key_d;
      found_q         <= found_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      init_start_q    <= init_start_d;
      shuffle_start_q <= shuffle_start_d;
      decrypt_start_q <= decrypt_start_d;
    end
  end

  // S-RAM grant: one engine per phase; writes are only honoured in RUN.
  always_comb begin
    s_address      = '0;
    s_ram_in       = '0;
    s_write_enable = 1'b0;
    case (state_q)
      ST_INIT_GO, ST_INIT_RUN: begin
        s_address      = init_address;
        s_ram_in       = init_ram_in;
        s_write_enable = init_write_enable & (state_q == ST_INIT_RUN);
      end
      ST_SHUF_GO, ST_SHUF_RUN: begin
        s_address      = shuffle_address;
        s_ram_in       = shuffle_ram_in;
        s_write_enable = shuffle_write_enable & (state_q == ST_SHUF_RUN);
      end
      ST_DEC_GO, ST_DEC_RUN: begin
        s_address      = decrypt_address;
        s_ram_in       = decrypt_ram_in;
        s_write_enable = decrypt_write_enable & (state_q == ST_DEC_RUN);
      end
      default: ;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign found         = found_q;
  assign key           = key_q;
  assign init_start    = init_start_q;
  assign shuffle_start = shuffle_start_q;
  assign decrypt_start = decrypt_start_q;

endmodule

// File: tb/tb_rc4_phase_controller.sv
// Directed bench for rc4_phase_controller with 5-cycle stub engines.
module tb_rc4_phase_controller;

  logic        clk, reset, start;
  logic        busy, done, found;
  logic [2:0][7:0] key;
  logic        init_start, shuffle_start, decrypt_start;
  logic        init_finished, shuffle_finished, decrypt_finished, decrypt_valid;
  logic [7:0]  s_address, s_ram_in;
  logic        s_write_enable;

  int total = 0;
  int bad   = 0;
  int valid_mode;     // 0 never, 1 always, 2 only when key == 3
  logic spur_shuf;
  logic mon_en;
  byte  seq[$];

  rc4_phase_controller #(
    .RAM_WIDTH(8), .RAM_LENGTH(8), .KEY_LENGTH(3), .KEY_START(0), .KEY_END(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .found(found), .key(key),
    .init_start(init_start), .shuffle_start(shuffle_start), .decrypt_start(decrypt_start),
    .init_finished(init_finished), .shuffle_finished(shuffle_finished),
    .decrypt_finished(decrypt_finished), .decrypt_valid(decrypt_valid),
    .init_address(8'h11), .shuffle_address(8'h22), .decrypt_address(8'h33),
    .init_ram_in(8'hA1), .shuffle_ram_in(8'hB2), .decrypt_ram_in(8'hC3),
    .init_write_enable(1'b1), .shuffle_write_enable(1'b1), .decrypt_write_enable(1'b1),
    .s_address(s_address), .s_ram_in(s_ram_in), .s_write_enable(s_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub engines: finished pulses on the 6th edge with start high.
  logic [2:0] cnt_i, cnt_s, cnt_d;
  logic       fin_i, fin_s, fin_d;
  always @(posedge clk) begin
    if (reset) begin
      cnt_i <= 3'd0; cnt_s <= 3'd0; cnt_d <= 3'd0;
      fin_i <= 1'b0; fin_s <= 1'b0; fin_d <= 1'b0;
    end else begin
      cnt_i <= init_start    ? cnt_i + 3'd1 : 3'd0;
      cnt_s <= shuffle_start ? cnt_s + 3'd1 : 3'd0;
      cnt_d <= decrypt_start ? cnt_d + 3'd1 : 3'd0;
      fin_i <= init_start    && cnt_i == 3'd4 && !fin_i;
      fin_s <= shuffle_start && cnt_s == 3'd4 && !fin_s;
      fin_d <= decrypt_start && cnt_d == 3'd4 && !fin_d;
    end
  end
  assign init_finished    = fin_i;
  assign shuffle_finished = fin_s | spur_shuf;
  assign decrypt_finished = fin_d;
  assign decrypt_valid    = (valid_mode == 1) || (valid_mode == 2 && key == 24'h000003);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Record engine start rising edges in order.
  logic pi, ps, pd;
  always @(posedge clk) begin
    if (init_start && !pi)    seq.push_back("I");
    if (shuffle_start && !ps) seq.push_back("S");
    if (decrypt_start && !pd) seq.push_back("D");
    pi <= init_start; ps <= shuffle_start; pd <= decrypt_start;
  end

  // Bus ownership checked every cycle against the start outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) begin
        chk("idle_addr", 32'(s_address), 32'h0);
        chk("idle_data", 32'(s_ram_in), 32'h0);
        chk("idle_we", 32'(s_write_enable), 32'h0);
      end else if (init_start) begin
        chk("init_bus", {15'd0, s_write_enable, s_address, s_ram_in}, 32'h111A1);
      end else if (shuffle_start) begin
        chk("shuf_bus", {15'd0, s_write_enable, s_address, s_ram_in}, 32'h122B2);
      end else if (decrypt_start) begin
        chk("dec_bus", {15'd0, s_write_enable, s_address, s_ram_in}, 32'h133C3);
      end else begin
        chk("go_we", 32'(s_write_enable), 32'h0);
      end
    end
  end

  // Pulse start, then count edges until done (bounded). Optionally inject a
  // spurious shuffle_finished plus a start edge while in INIT_RUN.
  task automatic run(input int inj, input int exp_lat);
    int n;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    chk("go_busy", 32'(busy), 32'h1);
    chk("go_init_low", 32'(init_start), 32'h0);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        start = 1'b0;
        chk("init_start_hi", 32'(init_start), 32'h1);
        chk("attempt_key", 32'(key), 32'h0);
      end
      if (inj != 0 && n == inj) begin
        spur_shuf = 1'b1; start = 1'b1;
      end
      if (inj != 0 && n == inj + 1) begin
        spur_shuf = 1'b0; start = 1'b0;
        chk("spur_init_hold", 32'(init_start), 32'h1);
        chk("spur_shuf_low", 32'(shuffle_start), 32'h0);
        chk("spur_busy", 32'(busy), 32'h1);
      end
    end
    chk("latency", 32'(n), 32'(exp_lat));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; valid_mode = 1; spur_shuf = 1'b0; mon_en = 1'b0;
    pi = 1'b0; ps = 1'b0; pd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_found", 32'(found), 32'h0);
    chk("rst_key", 32'(key), 32'h0);
    chk("rst_starts", {29'd0, init_start, shuffle_start, decrypt_start}, 32'h0);
    chk("rst_bus", {15'd0, s_write_enable, s_address, s_ram_in}, 32'h0);
    @(negedge clk) reset = 1'b0; mon_en = 1'b1;

    // Valid on first key: one attempt, 3 phases of 7 cycles.
    seq.delete();
    run(0, 21);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_found", 32'(found), 32'h1);
    chk("t1_key", 32'(key), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_nseq", 32'(seq.size()), 32'd3);
    if (seq.size() == 3) begin
      chk("t1_seq0", 32'(seq[0]), 32'("I"));
      chk("t1_seq1", 32'(seq[1]), 32'("S"));
      chk("t1_seq2", 32'(seq[2]), 32'("D"));
    end

    // Spurious shuffle_finished and start edge while busy are ignored.
    seq.delete();
    run(3, 21);
    chk("t2_found", 32'(found), 32'h1);
    chk("t2_nseq", 32'(seq.size()), 32'd3);

    // Valid only at key 3 (last key): 4 attempts, 3*22 + 21 cycles.
    valid_mode = 2;
    seq.delete();
    run(0, 87);
    chk("t3_found", 32'(found), 32'h1);
    chk("t3_key", 32'(key), 32'h3);
    chk("t3_nseq", 32'(seq.size()), 32'd12);

    // Never valid: exhausts at KEY_END with found=0, then stays put.
    valid_mode = 0;
    seq.delete();
    run(0, 87);
    chk("t4_found", 32'(found), 32'h0);
    chk("t4_key", 32'(key), 32'h3);
    repeat (30) @(posedge clk);
    #1;
    chk("t4_quiet", 32'(seq.size()), 32'd12);
    chk("t4_done_hold", 32'(done), 32'h1);

    // Reset in the second attempt's SHUF_RUN.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    chk("t5_in_shuf", 32'(shuffle_start), 32'h1);
    chk("t5_key1", 32'(key), 32'h1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_key", 32'(key), 32'h0);
    chk("t5_starts", {29'd0, init_start, shuffle_start, decrypt_start}, 32'h0);
    chk("t5_bus", {15'd0, s_write_enable, s_address, s_ram_in}, 32'h0);
    @(negedge clk) reset = 1'b0;
    valid_mode = 1;
    run(0, 21);
    chk("t5_found", 32'(found), 32'h1);
    chk("t5_key_end", 32'(key), 32'h0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rc4_phase_controller.md
# rc4_phase_controller

Top-level sequencer for the RC4 key-search datapath. It runs the three S-RAM engines (init, shuffle, decrypt) in order for one candidate key and owns the single-port S memory, muxing exactly one engine onto it at a time. It supplies the candidate key to shuffle/decrypt and steps through the key space until decrypt reports a valid message or the space is exhausted.

## Interface
- RAM_WIDTH, 8, S-RAM data width and key byte width
- RAM_LENGTH, 8, S-RAM address width
- KEY_LENGTH, 3, key bytes; key vector is KEY_LENGTH*RAM_WIDTH bits
- KEY_START, 0, first candidate key (integer)
- KEY_END, 24'h3FFFFF, last candidate key (integer, inclusive)

- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  run request; rising edge is the trigger
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level, high in DONE
- found  out  1  valid while done; 1 = key located
- key  out  [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  current/final candidate, byte KEY_LENGTH-1 is first key byte
- init_start, shuffle_start, decrypt_start  out  1 each  engine start levels
- init_finished, shuffle_finished, decrypt_finished  in  1 each  one-cycle engine done pulses
- decrypt_valid  in  1  sampled with decrypt_finished; 1 = plaintext passed check
- {init,shuffle,decrypt}_address  in  RAM_LENGTH  engine S address
- {init,shuffle,decrypt}_ram_in  in  RAM_WIDTH  engine write data
- {init,shuffle,decrypt}_write_enable  in  1  engine write strobe
- s_address  out  RAM_LENGTH  to S-RAM
- s_ram_in  out  RAM_WIDTH  to S-RAM
- s_write_enable  out  1  to S-RAM

## Operation
- States: IDLE, INIT_GO, INIT_RUN, SHUF_GO, SHUF_RUN, DEC_GO, DEC_RUN, NEXT_KEY, DONE.
- IDLE/DONE + start edge -> INIT_GO; key <= KEY_START; found <= 0.
- X_GO -> X_RUN unconditionally (1 cycle, X's start low: guarantees a low cycle before each engine's edge).
- X_start = (state == X_RUN); held high until X_finished.
- INIT_RUN + init_finished -> SHUF_GO; SHUF_RUN + shuffle_finished -> DEC_GO.
- DEC_RUN + decrypt_finished: valid -> DONE, found <= 1; else key == KEY_END -> DONE, found <= 0; else -> NEXT_KEY.
- NEXT_KEY: key <= key + 1 (full KEY_LENGTH*RAM_WIDTH-bit add) -> INIT_GO.
- key constant from INIT_GO through DEC_RUN of an attempt.
- Bus grant: INIT_* -> init, SHUF_* -> shuffle, DEC_* -> decrypt, else none. Address/data pass through combinationally; s_write_enable forced 0 in GO states and when no grant. No grant: s_address 0, s_ram_in 0, s_write_enable 0.
- finished pulses outside the matching RUN state ignored; start edges while busy ignored.
- Reset values: state IDLE, all *_start 0, busy 0, done 0, found 0, key KEY_START, s_* 0.

## Timing
- start high first sampled at edge k -> INIT_GO after k, init_start high after k+1.
- X_finished sampled at edge m -> X_start low after m; next engine start high after m+1.
- Per-attempt overhead: 4 cycles (3 GO + NEXT_KEY) beyond engine runtimes.
- done/found update on the edge that samples the last decrypt_finished.
- Reset mid-run: next cycle IDLE, starts low, bus idle; S contents undefined, next run re-inits.
- KEY_START == KEY_END: single attempt.

## Structure
- Shared package rc4_pkg: state enum type, KEY_BITS constant.
- Sub-module: existing edge_detector (clk, in, out) on start.
- Grant mux in a separate always_comb.

## Test plan
- Stub engines finish after 5 cycles, decrypt_valid=1 on first try -> start pulses init/shuffle/decrypt in order, each with low gap, done=1, found=1, key=0.
- decrypt_valid=1 only when key==3 -> 4 attempts, done with key=24'h000003, found=1.
- KEY_END=2, valid never -> done, found=0, key=2; no further start pulses.
- Engines drive distinct addresses/writes -> s_* equals granted engine only; s_write_enable 0 in every GO cycle.
- Reset asserted during SHUF_RUN -> next cycle all outputs at reset values; new start edge restarts at INIT with key=KEY_START.
- Spurious shuffle_finished during INIT_RUN and start edge while busy -> no state change.
